// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master bus arbiter with split-transaction support.
//                States IDLE / GRANT / OWNED; a granted master that never
//                raises its util flag is timed out after 8 cycles. A BUSY
//                response from the owner parks the transaction as a split,
//                which is resumed in IDLE once the slave signals split_ready.
//                Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie
//                breaking; without it master 1 wins every tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_req1,
    input  logic       bus_req2,
    input  logic       util1,
    input  logic       util2,
    input  logic [1:0] response,
    input  logic       split_ready,
    output logic       grant1,
    output logic       grant2,
    output logic       msel,
    output logic       split_active,
    output logic       split_owner,
    output logic       split_err
);

    localparam logic [1:0] c_RESP_BUSY = 2'b01;
    localparam logic [2:0] c_TMO_LAST  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_OWNED = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_grant1;
    logic       r_grant2;
    logic       r_msel;
    logic       r_split_active;
    logic       r_split_owner;
    logic       r_split_err;
    logic       r_resume;      // current grant is the resumption of the split
    logic [2:0] r_tmo;         // cycles spent in GRANT without util
`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last_winner; // 0 = M1, 1 = M2
`endif

    logic w_req1_eff;
    logic w_req2_eff;
    logic w_any_req;
    logic w_pick_m2;
    logic w_resume;
    logic w_owner_util;

    // Requests from the master that owns a pending split are ignored
    assign w_req1_eff   = bus_req1 & ~(r_split_active & ~r_split_owner);
    assign w_req2_eff   = bus_req2 & ~(r_split_active &  r_split_owner);
    assign w_any_req    = w_req1_eff | w_req2_eff;
    assign w_resume     = r_split_active & split_ready;
    assign w_owner_util = r_msel ? util2 : util1;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the master not granted most recently wins
    assign w_pick_m2 = w_req2_eff & (~w_req1_eff | ~r_last_winner);
`else
    // Fixed priority: M2 wins only when M1 is not requesting
    assign w_pick_m2 = w_req2_eff & ~w_req1_eff;
`endif

    // Arbitration state machine with registered grant/split outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_grant1       <= 1'b0;
            r_grant2       <= 1'b0;
            r_msel         <= 1'b0;
            r_split_active <= 1'b0;
            r_split_owner  <= 1'b0;
            r_split_err    <= 1'b0;
            r_resume       <= 1'b0;
            r_tmo          <= 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_winner  <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tmo <= 3'd0;
                    if (w_resume) begin
                        // Resuming the split beats any new request
                        r_grant1 <= ~r_split_owner;
                        r_grant2 <=  r_split_owner;
                        r_msel   <=  r_split_owner;
                        r_resume <= 1'b1;
                        r_state  <= S_GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_winner <= r_split_owner;
`endif
                    end else if (w_any_req) begin
                        r_grant1 <= ~w_pick_m2;
                        r_grant2 <=  w_pick_m2;
                        r_msel   <=  w_pick_m2;
                        r_resume <= 1'b0;
                        r_state  <= S_GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_winner <= w_pick_m2;
`endif
                    end
                end

                S_GRANT: begin
                    if (w_owner_util) begin
                        r_state  <= S_OWNED;
                        r_resume <= 1'b0;
                        if (r_resume) begin
                            r_split_active <= 1'b0;
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        // Eighth cycle without util: give the bus back
                        r_grant1 <= 1'b0;
                        r_grant2 <= 1'b0;
                        r_resume <= 1'b0;
                        r_tmo    <= 3'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 3'd1;
                    end
                end

                S_OWNED: begin
                    if (response == c_RESP_BUSY) begin
                        // Only one split can be parked; a second one is flagged
                        if (!r_split_active) begin
                            r_split_active <= 1'b1;
                            r_split_owner  <= r_msel;
                        end else begin
                            r_split_err    <= 1'b1;
                        end
                        r_grant1 <= 1'b0;
                        r_grant2 <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (!w_owner_util) begin
                        r_grant1 <= 1'b0;
                        r_grant2 <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_grant1 <= 1'b0;
                    r_grant2 <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign grant1       = r_grant1;
    assign grant2       = r_grant2;
    assign msel         = r_msel;
    assign split_active = r_split_active;
    assign split_owner  = r_split_owner;
    assign split_err    = r_split_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. Directed scenarios
//                followed by random traffic, all compared cycle by cycle
//                against a transaction-level reference model.
//                Honours ARB_ROUND_ROBIN_EN for tie-break expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       bus_req1, bus_req2, util1, util2, split_ready;
    logic [1:0] response;
    logic       grant1, grant2, msel, split_active, split_owner, split_err;

    int errors;
    int checks;

    // Reference model: who holds the bus (0 none, 1 M1, 2 M2), whether the
    // holder has taken ownership, and how long it has waited for util.
    int m_holder;
    bit m_owned;
    int m_age;
    bit m_resume;
    bit m_sa;
    int m_so;
    bit m_serr;
    int m_ms;
    int m_last;

    bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .bus_req1     (bus_req1),
        .bus_req2     (bus_req2),
        .util1        (util1),
        .util2        (util2),
        .response     (response),
        .split_ready  (split_ready),
        .grant1       (grant1),
        .grant2       (grant2),
        .msel         (msel),
        .split_active (split_active),
        .split_owner  (split_owner),
        .split_err    (split_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_holder = 0; m_owned = 0; m_age = 0; m_resume = 0;
        m_sa = 0; m_so = 1; m_serr = 0; m_ms = 1; m_last = 2;
    endtask

    task automatic grant_to(input int who, input bit resume);
        m_holder = who; m_ms = who; m_owned = 0; m_age = 0;
        m_resume = resume; m_last = who;
    endtask

    // One rising edge of the reference model, using the inputs now applied
    task automatic model_step();
        bit r1, r2, u;
        int w;
        u = (m_holder == 2) ? util2 : util1;
        if (m_holder == 0) begin
            if (m_sa && split_ready) begin
                grant_to(m_so, 1'b1);
            end else begin
                r1 = bus_req1 && !(m_sa && m_so == 1);
                r2 = bus_req2 && !(m_sa && m_so == 2);
                w = 0;
                if (r1 && r2) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = (m_last == 1) ? 2 : 1;
`else
                    w = 1;
`endif
                end else if (r1) w = 1;
                else if (r2) w = 2;
                if (w != 0) grant_to(w, 1'b0);
            end
        end else if (!m_owned) begin
            if (u) begin
                m_owned = 1;
                if (m_resume) m_sa = 0;
            end else begin
                m_age++;
                if (m_age == 8) m_holder = 0;
            end
        end else begin
            if (response == 2'b01) begin
                if (!m_sa) begin m_sa = 1; m_so = m_holder; end
                else m_serr = 1;
                m_holder = 0;
            end else if (!u) begin
                m_holder = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("grant1",       grant1,       m_holder == 1);
        chk("grant2",       grant2,       m_holder == 2);
        chk("msel",         msel,         m_ms == 2);
        chk("split_active", split_active, m_sa);
        chk("split_owner",  split_owner,  m_so == 2);
        chk("split_err",    split_err,    m_serr);
    endtask

    // Advance n clock cycles, checking outputs on each falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic clear_inputs();
        bus_req1 = 0; bus_req2 = 0; util1 = 0; util2 = 0;
        response = 2'b00; split_ready = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_grant1",  grant1,       1'b0);
        chk("rst_grant2",  grant2,       1'b0);
        chk("rst_msel",    msel,         1'b0);
        chk("rst_split",   split_active, 1'b0);
        chk("rst_owner",   split_owner,  1'b0);
        chk("rst_err",     split_err,    1'b0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [2:0] rr_exp;

    initial begin
        errors = 0;
        checks = 0;
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // Simultaneous request: M1 wins, then M2 after M1 releases
        bus_req1 = 1; bus_req2 = 1;
        step(1);
        chk("tie_g1", grant1, 1'b1);
        chk("tie_msel", msel, 1'b0);
        util1 = 1; step(1);
        util1 = 0; bus_req1 = 0; step(1);
        chk("release_g1", grant1, 1'b0);
        step(1);
        chk("next_g2", grant2, 1'b1);
        util2 = 1; step(2);
        util2 = 0; bus_req2 = 0; step(2);

        // M2 split, M1 takes the bus, resume deferred until M1 releases
        bus_req2 = 1; step(1);
        util2 = 1; step(1);
        response = 2'b01; step(1);
        chk("split_set", split_active, 1'b1);
        chk("split_m2", split_owner, 1'b1);
        response = 2'b00; util2 = 0; bus_req2 = 0;
        bus_req1 = 1; step(1);
        chk("m1_during_split", grant1, 1'b1);
        util1 = 1; step(1);
        split_ready = 1; step(3);
        chk("no_preempt", grant2, 1'b0);
        util1 = 0; bus_req1 = 0; step(1);
        step(1);
        chk("resume_g2", grant2, 1'b1);
        util2 = 1; step(1);
        chk("resume_clear", split_active, 1'b0);
        util2 = 0; split_ready = 0; step(2);

        // Timeout: grant without util drops after eight cycles
        bus_req1 = 1; step(1);
        bus_req1 = 0; step(7);
        chk("tmo_hold", grant1, 1'b1);
        step(1);
        chk("tmo_drop", grant1, 1'b0);
        chk("tmo_nosplit", split_active, 1'b0);
        step(1);

        // Second split while one is pending
        bus_req1 = 1; step(1);
        util1 = 1; step(1);
        response = 2'b01; step(1);
        response = 2'b00; util1 = 0; bus_req1 = 0;
        bus_req2 = 1; step(1);
        util2 = 1; step(1);
        response = 2'b01; step(1);
        chk("err_set", split_err, 1'b1);
        chk("err_owner", split_owner, 1'b0);
        chk("err_g2", grant2, 1'b0);
        response = 2'b00; util2 = 0; step(1);

        // Reset while M2 holds the bus and a split is pending
        step(1);
        chk("pre_rst_g2", grant2, 1'b1);
        chk("pre_rst_sa", split_active, 1'b1);
        do_reset();

        // Repeated ties: alternation under round robin, M1 otherwise
`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = 3'b010;
`else
        rr_exp = 3'b000;
`endif
        bus_req1 = 1; bus_req2 = 1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk($sformatf("tie_winner%0d", k), grant2, rr_exp[k]);
            if (m_holder == 2) util2 = 1; else util1 = 1;
            step(1);
            util1 = 0; util2 = 0;
            step(1);
        end
        clear_inputs();
        step(2);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bus_req1    = $urandom_range(0, 1);
            bus_req2    = $urandom_range(0, 1);
            util1       = ($urandom_range(0, 3) != 0);
            util2       = ($urandom_range(0, 3) != 0);
            split_ready = ($urandom_range(0, 2) == 0);
            response    = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b10;
            step(1);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 bus_req1, bus_req2  input  1 each  bus request from master 1 / master 2 interface.
REQ-004 util1, util2  input  1 each  bus-utilized flag from master 1 / master 2 interface.
REQ-005 response  input  2  slave response bus: NCK=00, BUSY=01, OK=10, DONE=11.
REQ-006 split_ready  input  1  slave is ready to resume the split transaction.
REQ-007 grant1, grant2  output  1 each  registered grant to master 1 / master 2.
REQ-008 msel  output  1  bus mux select: 0 = master 1, 1 = master 2.
REQ-009 split_active  output  1  a split transaction is pending.
REQ-010 split_owner  output  1  master holding the pending split: 0 = M1, 1 = M2.
REQ-011 split_err  output  1  sticky flag: a second split was attempted while one was pending.

Function
REQ-012 The arbiter SHALL implement states IDLE, GRANT, OWNED; at most one grant is high in any cycle.
REQ-013 IDLE, no grant: if split_active=1 and split_ready=1, the arbiter SHALL grant split_owner; resuming the split beats all new requests.
REQ-014 IDLE otherwise: if any bus_req is high, the arbiter SHALL grant the winner, set msel, and go to GRANT; grant rises one clock after the request is sampled.
REQ-015 In fixed-priority mode, M1 SHALL win a simultaneous request.
REQ-016 While split_active=1, a bus_req from split_owner SHALL be ignored.
REQ-017 GRANT: grant is held; when the granted master's util=1, the arbiter SHALL go to OWNED; if split resume, clear split_active on that edge.
REQ-018 GRANT: if util is not seen within 8 cycles of grant rising, a 3-bit timeout counter SHALL drop grant and return to IDLE.
REQ-019 OWNED: grant is held while owner util=1; when util falls, the arbiter SHALL drop grant next edge and return to IDLE.
REQ-020 OWNED, response=BUSY, split_active=0: the arbiter SHALL set split_active=1 and split_owner=msel, drop grant, and go to IDLE.
REQ-021 OWNED, response=BUSY, split_active=1: the arbiter SHALL set split_err=1, keep the existing split record, and drop grant.
REQ-022 split_ready while another master is in GRANT/OWNED SHALL NOT preempt; the resume is serviced on return to IDLE if split_ready is still high.
REQ-023 msel SHALL retain its last value when no grant is active.
REQ-024 Back-to-back request: a request present in the IDLE cycle after a release SHALL be granted with no extra idle cycle.

Reset
REQ-025 On reset=1, asynchronously: state=IDLE, grant1=grant2=0, msel=0, split_active=0, split_owner=0, split_err=0, timeout counter=0.
REQ-026 Reset mid-transaction SHALL drop grants immediately and discard any pending split.

Configuration
REQ-027 With macro ARB_ROUND_ROBIN_EN defined: on a tie, the master not granted most recently SHALL win; the last-winner register resets to M2 so M1 wins the first tie.
REQ-028 Without ARB_ROUND_ROBIN_EN: fixed priority, M1 wins every tie; no last-winner register.

Verification
REQ-029 bus_req1=bus_req2=1 at edge 0 -> grant1=1 after edge 1, msel=0; M1 raises util1 -> OWNED; util1 falls -> grant1=0 next edge, then grant2=1.
REQ-030 M2 owns the bus, response=01 -> split_active=1, split_owner=1, grant2=0; M1 requests -> grant1=1; split_ready=1 during M1 ownership -> no grant2 until util1 falls, then grant2=1 and split_active clears when util2=1.
REQ-031 Grant given, util never rises -> grant drops after 8 cycles, state IDLE, no split recorded.
REQ-032 split_active=1 from M1, M2 owns the bus and gets response=01 -> split_err=1, split_owner stays 0, grant2=0.
REQ-033 ARB_ROUND_ROBIN_EN defined, both masters request repeatedly -> grants alternate M1, M2, M1; undefined -> M1 every time.
REQ-034 reset pulsed while grant2=1 and split_active=1 -> all outputs 0 within the same cycle.
